pid_controller: RTL and testbench
=================================

Name: pid_controller

Overview:
- Discrete-time fixed-point PID controller.
- Gains are programmed through a small register-write port.
- While iteration is enabled it runs back-to-back control updates: out = Kp·e + Ki·Σe + Kd·(e − e_prev), with e = target − measurement.
- Each result is announced with a one-cycle out_valid pulse. It sits between a setpoint source and a plant/actuator path that feeds measurement back.

Parameters:
- D_WIDTH, 16, width of data, gains, target, measurement and out (two's complement).
- Q_BITS, 13, fractional bits of the gain format (gain 1.0 = 2^Q_BITS).

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rstb  in  1  synchronous, active-low reset.
- write_enable  in  1  active-low register write strobe.
- iterate_enable  in  1  active-high run enable.
- reg_addr  in  D_WIDTH  register address.
- reg_data  in  D_WIDTH  register write data (signed gain).
- target  in  D_WIDTH  signed setpoint.
- measurement  in  D_WIDTH  signed process variable.
- out  out  D_WIDTH  signed control output, held between updates.
- out_valid  out  1  one-cycle pulse when out is updated.

Behaviour:
- Reset (rstb=0 at a clk edge):
  - Kp, Ki and Kd clear to 0.
  - Integrator and e_prev clear to 0.
  - out clears to 0 and out_valid to 0.
  - FSM goes to IDLE.
  - Reset applies even mid-iteration; the partial result is discarded.
- Register writes: when write_enable=0 at a clk edge, reg_data is written to the addressed gain.
  - addr 0 = Kp, addr 1 = Ki, addr 2 = Kd.
  - Other addresses are ignored.
  - Writes are accepted in any FSM state and take effect from the next cycle. A gain changed mid-iteration is used by any multiply not yet performed.
- FSM: IDLE → CAPTURE → MUL_P → MUL_I → MUL_D → SUM → DONE. It uses one shared signed multiplier.
  - IDLE: stay while iterate_enable=0; go to CAPTURE when it is 1.
  - CAPTURE: register e = sat(target − measurement). Inputs are sampled only in this cycle.
  - MUL_P: P = (Kp·e) >>> Q_BITS.
  - MUL_I: integ = sat(integ + e), then I = (Ki·integ) >>> Q_BITS. The multiply uses the updated integ.
  - MUL_D: d = sat(e − e_prev), then D = (Kd·d) >>> Q_BITS.
  - SUM: out ← sat(P + I + D); e_prev ← e.
  - DONE: out_valid=1 for exactly this cycle. Next state is CAPTURE if iterate_enable=1, else IDLE.
- Latency: out_valid is asserted 5 cycles after the CAPTURE cycle, so the update period is 6 cycles.
  - measurement may change after the out_valid edge; the new value is picked up in the following CAPTURE.
- Dropping iterate_enable mid-iteration does not abort: the current update completes, then the FSM returns to IDLE.
  - Integrator and e_prev are retained across IDLE; only reset clears them.
- Arithmetic:
  - Products are 2·D_WIDTH signed.
  - Shifts are arithmetic (truncation toward −∞).
  - Sums use at least D_WIDTH+3 bits internally.
  - Every stored or output value saturates to [−2^(D_WIDTH−1), 2^(D_WIDTH−1)−1].

Decomposition:
- Package pid_pkg holds:
  - register address constants ADDR_KP=0, ADDR_KI=1, ADDR_KD=2;
  - the FSM state enum;
  - a saturate function (wide signed → D_WIDTH).
- One sub-module, pid_sat_mac: signed multiply, arithmetic shift by Q_BITS, saturate. It is shared by the three gain terms.

Test Plan:
- Reset then idle: out=0, out_valid=0. With iterate_enable=0 no pulses occur, even when target=1000.
- P only: Kp=4096 (0.5), Ki=Kd=0, target=1000, measurement=0 → out=500, out_valid pulse every 6 cycles. With target=−3 → out=−2 (floor).
- I only: Ki=512 (0.0625), target=1000, measurement=0 fixed → outputs 62, 125, 187, 250 on successive pulses.
- D only: Kd=8192 (1.0). Iteration 1: target=100 → out=100. Iteration 2: same target → out=0.
- Saturation: Kp=32767, target=32767, measurement=−32768 → e saturates to 32767, out=32767. Mirror with target=−32768, measurement=32767 → out=−32768.
- Closed loop and reset:
  - Setup: Kp=512, Ki=4096, target=1000; after each pulse, measurement += out.
  - Required: measurement converges to within ±2 of 1000.
  - Reset mid-iteration: out=0 and no pulse until iterate_enable restarts.

Source files
------------

// File: rtl/pid_pkg.sv
// Shared definitions for the PID controller: register map, FSM states and
// a width-generic saturation helper.
package pid_pkg;

   localparam int unsigned ADDR_KP = 0;
   localparam int unsigned ADDR_KI = 1;
   localparam int unsigned ADDR_KD = 2;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CAPTURE,
      S_MUL_P,
      S_MUL_I,
      S_MUL_D,
      S_SUM,
      S_DONE
   } pid_state_e;

   // Clamps a wide signed value to the range of a signed 'width'-bit number.
   // Callers narrow the 64-bit result with a size cast.
   function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                    input int unsigned width);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (value > max_v) begin
         return max_v;
      end
      if (value < min_v) begin
         return min_v;
      end
      return value;
   endfunction

endpackage

// File: rtl/pid_sat_mac.sv
// Shared gain multiplier: signed product, arithmetic shift by the gain's
// fractional bits, then saturation back to the data width.
module pid_sat_mac
   import pid_pkg::*;
#(
   parameter int D_WIDTH = 16,
   parameter int Q_BITS  = 13
) (
   input  logic signed [D_WIDTH-1:0] coef,
   input  logic signed [D_WIDTH-1:0] operand,
   output logic signed [D_WIDTH-1:0] result
);

   logic signed [2*D_WIDTH-1:0] product;
   logic signed [2*D_WIDTH-1:0] shifted;

   always_comb begin
      product = coef * operand;
      shifted = product >>> Q_BITS;
      result  = D_WIDTH'(saturate(64'(shifted), D_WIDTH));
   end

endmodule

// File: rtl/pid_controller.sv
// Fixed-point PID controller: one update every six cycles while enabled,
// sharing a single saturating multiplier across the P, I and D terms.
module pid_controller
   import pid_pkg::*;
#(
   parameter int D_WIDTH = 16,
   parameter int Q_BITS  = 13
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               write_enable,
   input  logic               iterate_enable,
   input  logic [D_WIDTH-1:0] reg_addr,
   input  logic [D_WIDTH-1:0] reg_data,
   input  logic [D_WIDTH-1:0] target,
   input  logic [D_WIDTH-1:0] measurement,
   output logic [D_WIDTH-1:0] out,
   output logic               out_valid
);

   localparam int SUM_W = D_WIDTH + 3;

   pid_state_e state_q, state_d;

   logic signed [D_WIDTH-1:0] kp_q, kp_d;
   logic signed [D_WIDTH-1:0] ki_q, ki_d;
   logic signed [D_WIDTH-1:0] kd_q, kd_d;
   logic signed [D_WIDTH-1:0] e_q, e_d;
   logic signed [D_WIDTH-1:0] e_prev_q, e_prev_d;
   logic signed [D_WIDTH-1:0] integ_q, integ_d;
   logic signed [D_WIDTH-1:0] p_term_q, p_term_d;
   logic signed [D_WIDTH-1:0] i_term_q, i_term_d;
   logic signed [D_WIDTH-1:0] d_term_q, d_term_d;
   logic signed [D_WIDTH-1:0] out_q, out_d;
   logic                      out_valid_q, out_valid_d;

   logic signed [D_WIDTH-1:0] integ_upd;
   logic signed [D_WIDTH-1:0] e_delta;
   logic signed [D_WIDTH-1:0] e_new;
   logic signed [SUM_W-1:0]   term_sum;
   logic signed [D_WIDTH-1:0] mac_coef;
   logic signed [D_WIDTH-1:0] mac_operand;
   logic signed [D_WIDTH-1:0] mac_result;

   pid_sat_mac #(
      .D_WIDTH (D_WIDTH),
      .Q_BITS  (Q_BITS)
   ) u_mac (
      .coef    (mac_coef),
      .operand (mac_operand),
      .result  (mac_result)
   );

   // Operand selection kept apart from next-state logic so the multiplier
   // path does not form a false loop through one combinational block.
   always_comb begin
      e_new       = D_WIDTH'(saturate(64'(signed'(target)) - 64'(signed'(measurement)), D_WIDTH));
      integ_upd   = D_WIDTH'(saturate(64'(integ_q) + 64'(e_q), D_WIDTH));
      e_delta     = D_WIDTH'(saturate(64'(e_q) - 64'(e_prev_q), D_WIDTH));
      term_sum    = SUM_W'(p_term_q) + SUM_W'(i_term_q) + SUM_W'(d_term_q);
      mac_coef    = '0;
      mac_operand = '0;
      case (state_q)
         S_MUL_P: begin
            mac_coef    = kp_q;
            mac_operand = e_q;
         end
         S_MUL_I: begin
            mac_coef    = ki_q;
            mac_operand = integ_upd;
         end
         S_MUL_D: begin
            mac_coef    = kd_q;
            mac_operand = e_delta;
         end
         default: begin
            mac_coef    = '0;
            mac_operand = '0;
         end
      endcase
   end

   always_comb begin
      state_d     = state_q;
      kp_d        = kp_q;
      ki_d        = ki_q;
      kd_d        = kd_q;
      e_d         = e_q;
      e_prev_d    = e_prev_q;
      integ_d     = integ_q;
      p_term_d    = p_term_q;
      i_term_d    = i_term_q;
      d_term_d    = d_term_q;
      out_d       = out_q;
      out_valid_d = 1'b0;

      // Gain writes are independent of the sequencer and land on the next edge.
      if (!write_enable) begin
         if (reg_addr == D_WIDTH'(ADDR_KP)) begin
            kp_d = signed'(reg_data);
         end else if (reg_addr == D_WIDTH'(ADDR_KI)) begin
            ki_d = signed'(reg_data);
         end else if (reg_addr == D_WIDTH'(ADDR_KD)) begin
            kd_d = signed'(reg_data);
         end
      end

      case (state_q)
         S_IDLE: begin
            if (iterate_enable) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            e_d     = e_new;
            state_d = S_MUL_P;
         end
         S_MUL_P: begin
            p_term_d = mac_result;
            state_d  = S_MUL_I;
         end
         S_MUL_I: begin
            integ_d  = integ_upd;
            i_term_d = mac_result;
            state_d  = S_MUL_D;
         end
         S_MUL_D: begin
            d_term_d = mac_result;
            state_d  = S_SUM;
         end
         S_SUM: begin
            out_d       = D_WIDTH'(saturate(64'(term_sum), D_WIDTH));
            e_prev_d    = e_q;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            state_d = iterate_enable ? S_CAPTURE : S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state_q     <= S_IDLE;
         kp_q        <= '0;
         ki_q        <= '0;
         kd_q        <= '0;
         e_q         <= '0;
         e_prev_q    <= '0;
         integ_q     <= '0;
         p_term_q    <= '0;
         i_term_q    <= '0;
         d_term_q    <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         kp_q        <= kp_d;
         ki_q        <= ki_d;
         kd_q        <= kd_d;
         e_q         <= e_d;
         e_prev_q    <= e_prev_d;
         integ_q     <= integ_d;
         p_term_q    <= p_term_d;
         i_term_q    <= i_term_d;
         d_term_q    <= d_term_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_pid_controller.sv
// Scoreboard bench for pid_controller: a reference PID model queues the
// expected output at each launch and it is compared on the out_valid pulse.
module tb_pid_controller;

   localparam int DW = 16;
   localparam int QB = 13;

   logic          clk = 1'b0;
   logic          rstb;
   logic          write_enable;
   logic          iterate_enable;
   logic [DW-1:0] reg_addr;
   logic [DW-1:0] reg_data;
   logic [DW-1:0] target;
   logic [DW-1:0] measurement;
   logic [DW-1:0] out;
   logic          out_valid;

   always #5 clk = ~clk;

   pid_controller #(
      .D_WIDTH (DW),
      .Q_BITS  (QB)
   ) dut (
      .clk            (clk),
      .rstb           (rstb),
      .write_enable   (write_enable),
      .iterate_enable (iterate_enable),
      .reg_addr       (reg_addr),
      .reg_data       (reg_data),
      .target         (target),
      .measurement    (measurement),
      .out            (out),
      .out_valid      (out_valid)
   );

   int     checks   = 0;
   int     failures = 0;
   longint m_kp, m_ki, m_kd, m_integ, m_eprev;
   longint exp_q[$];
   longint last_out;
   longint meas;

   task automatic check_val(input string tag, input longint got, input longint exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic longint msat(input longint v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic longint model_step(input longint tgt, input longint mv);
      longint e, p, i, d, dd;
      e       = msat(tgt - mv);
      p       = msat((m_kp * e) >>> QB);
      m_integ = msat(m_integ + e);
      i       = msat((m_ki * m_integ) >>> QB);
      d       = msat(e - m_eprev);
      dd      = msat((m_kd * d) >>> QB);
      m_eprev = e;
      return msat(p + i + dd);
   endfunction

   function automatic longint dut_out();
      return longint'(signed'(out));
   endfunction

   // All tasks are entered just after a falling edge.
   task automatic write_reg(input int addr, input longint val);
      reg_addr     = 16'(addr);
      reg_data     = 16'(val);
      write_enable = 1'b0;
      @(negedge clk);
      write_enable = 1'b1;
      if (addr == 0) m_kp = val;
      else if (addr == 1) m_ki = val;
      else if (addr == 2) m_kd = val;
   endtask

   task automatic do_reset();
      rstb           = 1'b0;
      iterate_enable = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstb     = 1'b1;
      m_kp     = 0;
      m_ki     = 0;
      m_kd     = 0;
      m_integ  = 0;
      m_eprev  = 0;
      last_out = 0;
      exp_q.delete();
   endtask

   task automatic run_iter(input longint tgt, input longint mv, input bit keep, input string tag);
      int waited;
      bit seen;
      target         = 16'(tgt);
      measurement    = 16'(mv);
      iterate_enable = 1'b1;
      exp_q.push_back(model_step(tgt, mv));
      seen   = 1'b0;
      waited = 0;
      for (int n = 0; n < 12 && !seen; n++) begin
         @(negedge clk);
         waited++;
         if (!keep && n == 0) iterate_enable = 1'b0;
         if (out_valid) seen = 1'b1;
      end
      if (!seen) begin
         check_val({tag, "_timeout"}, 0, 1);
         if (exp_q.size() > 0) void'(exp_q.pop_front());
      end else begin
         check_val({tag, "_latency"}, waited, 6);
         last_out = exp_q.pop_front();
         check_val(tag, dut_out(), last_out);
      end
   endtask

   task automatic idle_watch(input int n, input string tag);
      int pulses;
      pulses = 0;
      repeat (n) begin
         @(negedge clk);
         if (out_valid) pulses++;
      end
      check_val({tag, "_pulses"}, pulses, 0);
      check_val({tag, "_hold"}, dut_out(), last_out);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rstb           = 1'b0;
      write_enable   = 1'b1;
      iterate_enable = 1'b0;
      reg_addr       = '0;
      reg_data       = '0;
      target         = '0;
      measurement    = '0;
      do_reset();
      check_val("reset_out", dut_out(), 0);
      check_val("reset_valid", longint'(out_valid), 0);
      target = 16'd1000;
      idle_watch(20, "idle");

      // Proportional only, including floor rounding of a negative product
      write_reg(0, 4096);
      run_iter(1000, 0, 1'b1, "p_pos");
      run_iter(1000, 0, 1'b1, "p_pos2");
      run_iter(-3, 0, 1'b0, "p_floor");
      idle_watch(10, "p_idle");

      // Integral only; unmapped addresses must not alias onto a gain
      do_reset();
      write_reg(1, 512);
      write_reg(4, 8192);
      write_reg(3, 8192);
      write_reg(16'hFFFF, 8192);
      for (int k = 0; k < 4; k++) begin
         run_iter(1000, 0, k < 3, "i_acc");
      end
      idle_watch(8, "i_idle");
      run_iter(1000, 0, 1'b0, "i_retained");

      // Derivative only
      do_reset();
      write_reg(2, 8192);
      run_iter(100, 0, 1'b1, "d_first");
      run_iter(100, 0, 1'b0, "d_second");

      // Saturation of error, product and sum at both rails
      do_reset();
      write_reg(0, 32767);
      run_iter(32767, -32768, 1'b1, "sat_pos");
      run_iter(-32768, 32767, 1'b0, "sat_neg");

      // Closed loop: plant integrates the controller output
      do_reset();
      write_reg(0, 512);
      write_reg(1, 4096);
      meas = 0;
      for (int k = 0; k < 400; k++) begin
         run_iter(1000, meas, k < 399, "loop");
         meas = msat(meas + dut_out());
      end
      check_val("loop_converged", longint'((meas >= 998) && (meas <= 1002)), 1);

      // Reset in the middle of an update discards it
      idle_watch(4, "pre_rst");
      target         = 16'd1000;
      measurement    = '0;
      iterate_enable = 1'b1;
      repeat (3) @(negedge clk);
      do_reset();
      check_val("rst_mid_out", dut_out(), 0);
      check_val("rst_mid_valid", longint'(out_valid), 0);
      idle_watch(15, "rst_mid");
      write_reg(0, 4096);
      run_iter(1000, 0, 1'b0, "restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
